// File: rtl/ext_pkg.sv
// Shared types and helpers for the load/immediate extension unit.
package ext_pkg;

    typedef enum logic [2:0] {
        EXT_SB       = 3'd0,
        EXT_UB       = 3'd1,
        EXT_SH       = 3'd2,
        EXT_UH       = 3'd3,
        EXT_W        = 3'd4,
        EXT_SIMM     = 3'd5,
        EXT_SIMM_SL2 = 3'd6,
        EXT_LUI      = 3'd7
    } ext_mode_t;

    localparam int IMM_W = 16;

    // Bit position of little-endian lane `lane` when lanes are `lane_w` bits wide.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/ext_skid_fifo.sv
// Two-entry in-order FIFO; ready depends only on the registered occupancy.
module ext_skid_fifo #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign push_ready = (r_count != 2'd2) && !reset;
    assign pop_valid  = (r_count != 2'd0);
    assign w_push     = push_valid && push_ready;
    assign w_pop      = pop_valid && pop_ready;

    // When empty, the slot behind the read pointer still holds the last delivered entry.
    assign pop_data = (r_count == 2'd0) ? r_mem[~r_rd_ptr] : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/load_extend_buffer.sv
// Sign/zero extension of load lanes and immediates, buffered through a 2-entry FIFO.
module load_extend_buffer
    import ext_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int ERRCNT_W = 8,
    localparam int OFF_W    = $clog2(DATA_W / 8)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  ext_mode_t           in_mode,
    input  logic [OFF_W-1:0]    in_offset,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_err,
    output logic [ERRCNT_W-1:0] err_count
);

    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [IMM_W-1:0]    w_imm;
    logic [DATA_W-1:0]   w_ext;
    logic                w_err;
    logic                w_push_ready;
    logic [DATA_W:0]     w_entry;
    logic [DATA_W:0]     w_head;
    logic [ERRCNT_W-1:0] r_err_count;

    assign w_byte = in_data[lane_lsb(int'(in_offset), 8) +: 8];
    assign w_half = in_data[lane_lsb(int'(in_offset[OFF_W-1:1]), 16) +: 16];
    assign w_imm  = in_data[IMM_W-1:0];

    always_comb begin
        w_ext = '0;
        w_err = 1'b0;
        case (in_mode)
            EXT_SB:       w_ext = DATA_W'($signed(w_byte));
            EXT_UB:       w_ext = DATA_W'(w_byte);
            EXT_SH: begin
                w_ext = DATA_W'($signed(w_half));
                w_err = in_offset[0];
            end
            EXT_UH: begin
                w_ext = DATA_W'(w_half);
                w_err = in_offset[0];
            end
            EXT_W: begin
                w_ext = DATA_W'($signed(in_data[31:0]));
                w_err = (in_offset != '0);
            end
            EXT_SIMM:     w_ext = DATA_W'($signed(w_imm));
            EXT_SIMM_SL2: w_ext = DATA_W'($signed(w_imm)) << 2;
            EXT_LUI:      w_ext = DATA_W'($signed({w_imm, 16'b0}));
            default: begin
                w_ext = '0;
                w_err = 1'b0;
            end
        endcase
    end

    // Misaligned requests still occupy a slot so results stay in request order.
    assign w_entry = w_err ? {1'b1, {DATA_W{1'b0}}} : {1'b0, w_ext};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (in_valid && w_push_ready && w_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERRCNT_W'(1);
        end
    end

    ext_skid_fifo #(
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (in_valid),
        .push_ready (w_push_ready),
        .push_data  (w_entry),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (w_head)
    );

    assign in_ready  = w_push_ready;
    assign out_err   = w_head[DATA_W];
    assign out_data  = w_head[DATA_W-1:0];
    assign err_count = r_err_count;

endmodule

// File: tb/tb_load_extend_buffer.sv
// Scoreboard bench for load_extend_buffer: driver queues expectations, monitor checks deliveries.
module tb_load_extend_buffer;
    import ext_pkg::*;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    ext_mode_t   in_mode;
    logic [1:0]  in_offset;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic [7:0]  err_count;

    logic        d2_in_ready;
    logic        d2_out_valid;
    logic [31:0] d2_out_data;
    logic        d2_out_err;
    logic [1:0]  d2_err_count;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_pops = 0;
    int   cyc    = 0;

    localparam logic [31:0] D = 32'h80F7_AD6A;

    load_extend_buffer #(.DATA_W(32), .ERRCNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_offset(in_offset), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .err_count(err_count)
    );

    load_extend_buffer #(.DATA_W(32), .ERRCNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d2_in_ready),
        .in_mode(in_mode), .in_offset(in_offset), .in_data(in_data),
        .out_valid(d2_out_valid), .out_ready(out_ready), .out_data(d2_out_data),
        .out_err(d2_out_err), .err_count(d2_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every delivered result must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                n_pops++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out got %h err %0d expected none", out_data, out_err);
                end else begin
                    e = q.pop_front();
                    chk("out", 64'({out_err, out_data}), 64'({e.err, e.data}));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    task automatic send(input ext_mode_t m, input logic [1:0] off, input logic [31:0] d,
                        input logic [31:0] ed, input logic ee);
        exp_t e;
        e.err  = ee;
        e.data = ed;
        in_valid  = 1'b1;
        in_mode   = m;
        in_offset = off;
        in_data   = d;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        int p0;
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_mode   = EXT_W;
        in_offset = 2'd0;
        in_data   = 32'h1234_5678;
        out_ready = 1'b1;

        // Reset held two cycles with a request presented
        repeat (2) begin
            @(negedge clk);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_data", 64'(out_data), 64'd0);
            chk("rst_err_count", 64'(err_count), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // All modes, back to back
        send(EXT_SB,       2'd1, D, 32'hFFFF_FFAD, 1'b0);
        send(EXT_UB,       2'd3, D, 32'h0000_0080, 1'b0);
        send(EXT_SH,       2'd2, D, 32'hFFFF_80F7, 1'b0);
        send(EXT_UH,       2'd0, D, 32'h0000_AD6A, 1'b0);
        send(EXT_SIMM,     2'd3, D, 32'hFFFF_AD6A, 1'b0);
        send(EXT_SIMM_SL2, 2'd0, D, 32'hFFFE_B5A8, 1'b0);
        send(EXT_LUI,      2'd0, D, 32'hAD6A_0000, 1'b0);
        send(EXT_W,        2'd0, D, 32'h80F7_AD6A, 1'b0);
        send(EXT_UB,       2'd2, D, 32'h0000_00F7, 1'b0);
        send(EXT_SH,       2'd0, 32'h0000_7FFF, 32'h0000_7FFF, 1'b0);
        idle(3);
        chk("err_none", 64'(err_count), 64'd0);

        // Misaligned requests
        send(EXT_SH, 2'd1, D, 32'h0, 1'b1);
        send(EXT_W,  2'd2, D, 32'h0, 1'b1);
        idle(3);
        chk("err_two", 64'(err_count), 64'd2);
        chk("err_two_w2", 64'(d2_err_count), 64'd2);
        send(EXT_SH, 2'd3, D, 32'h0, 1'b1);
        send(EXT_UH, 2'd1, D, 32'h0, 1'b1);
        send(EXT_W,  2'd1, D, 32'h0, 1'b1);
        idle(3);
        chk("err_five", 64'(err_count), 64'd5);
        chk("err_sat_w2", 64'(d2_err_count), 64'd3);

        // Back-pressure
        out_ready = 1'b0;
        send(EXT_UB, 2'd0, 32'h0000_0011, 32'h0000_0011, 1'b0);
        send(EXT_UB, 2'd0, 32'h0000_0022, 32'h0000_0022, 1'b0);
        in_valid  = 1'b1;
        in_mode   = EXT_UB;
        in_offset = 2'd0;
        in_data   = 32'h0000_0033;
        @(negedge clk);
        chk("bp_full_in_ready", 64'(in_ready), 64'd0);
        chk("bp_full_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_cycle_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_after_pop_in_ready", 64'(in_ready), 64'd1);
        if (in_ready) q.push_back(exp_t'({1'b0, 32'h0000_0033}));
        @(posedge clk);
        #1;
        idle(4);
        chk("bp_drained", 64'(q.size()), 64'd0);

        // Streaming: ten requests, one result per cycle
        c0 = cyc;
        p0 = n_pops;
        for (int i = 0; i < 10; i++) begin
            send(EXT_SIMM, 2'd0, 32'(i * 32'h1111 + 32'h8000), 32'(32'(signed'(16'(i * 32'h1111 + 32'h8000)))), 1'b0);
        end
        in_valid = 1'b0;
        chk("stream_cycles", 64'(cyc - c0), 64'd10);
        @(negedge clk);
        chk("stream_pops", 64'(n_pops - p0), 64'd10);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("stream_empty", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Reset while the buffer is full
        out_ready = 1'b0;
        send(EXT_UB, 2'd1, D, 32'h0000_00AD, 1'b0);
        send(EXT_SB, 2'd3, D, 32'hFFFF_FF80, 1'b0);
        @(negedge clk);
        chk("mid_full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_err_count", 64'(err_count), 64'd0);
        chk("mid_err_count_w2", 64'(d2_err_count), 64'd0);
        chk("mid_in_ready", 64'(in_ready), 64'd1);
        idle(6);
        chk("final_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_extend_buffer.md
# load_extend_buffer

Parametrised, buffered extension unit for the datapath: sign-extend and zero-extend of byte, halfword and immediate fields, plus the shifted immediate forms (branch offset ×4, LUI). Requests enter through a valid/ready port, are extended in the input cycle, and are held in a 2-entry output buffer. Sits between memory read data / instruction immediate field and the register-file write mux / ALU B-input. Replaces the fixed 16→32 sign extender.

## Interface
Parameters:
- DATA_W, 32, datapath width; power of two, ≥ 32.
- ERRCNT_W, 8, width of saturating misalignment error counter.
- OFF_W, log2(DATA_W/8), derived byte-offset width; not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit accepts request this cycle.
- in_mode  in  3  extension mode (ext_pkg::ext_mode_t).
- in_offset  in  OFF_W  byte address offset within in_data.
- in_data  in  DATA_W  memory word or instruction word.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result this cycle.
- out_data  out  DATA_W  extended result.
- out_err  out  1  result is from a misaligned request.
- err_count  out  ERRCNT_W  saturating count of accepted misaligned requests.

## Operation
- Accept when in_valid && in_ready; pop when out_valid && out_ready.
- Modes (value: function):
  - 0 SB: byte lane in_offset, sign-extended.
  - 1 UB: byte lane in_offset, zero-extended.
  - 2 SH: halfword lane in_offset[OFF_W-1:1], sign-extended; error if in_offset[0]=1.
  - 3 UH: as SH, zero-extended; same error rule.
  - 4 W: in_data[31:0] sign-extended to DATA_W (identity at 32); error if in_offset≠0.
  - 5 SIMM: in_data[15:0] sign-extended; in_offset ignored.
  - 6 SIMM_SL2: SIMM result shifted left 2, low bits zero.
  - 7 LUI: {sign-ext of in_data[15:0], 16'b0} truncated/extended to DATA_W.
- Lane k = in_data[8k+7:8k] (byte) / in_data[16k+15:16k] (half), little-endian.
- Error request: out_data = 0, out_err = 1; still enqueued and delivered in order.
- err_count increments by 1 per accepted error request, saturates at all-ones, never wraps.
- Buffer: FIFO, 2 entries, count ∈ {0,1,2}; strict in-order delivery.
- in_ready = (count ≠ 2) && !reset. out_valid = (count ≠ 0). out_data/out_err show head entry.
- Simultaneous push and pop: count unchanged, head advances, new entry appended.

## Timing
- Reset (sync, sampled at clk edge): count=0, out_valid=0, out_data=0, out_err=0, err_count=0; in_ready=0 while reset high, 1 the cycle after release.
- Reset mid-operation: buffered entries discarded, no output for them; any handshake in that cycle ignored.
- Latency: request accepted at edge N appears on out_* after edge N (visible cycle N+1).
- Throughput: 1 result/cycle with out_ready held high.
- in_ready is a function of registered count only (no combinational path from out_ready).
- Full (count=2): in_ready=0; pop at edge N → in_ready=1 from cycle N+1.
- Empty: out_valid=0; out_data holds last value (no X); consumer ignores it.
- Output data stable while out_valid && !out_ready.

## Structure
- ext_pkg: ext_mode_t enum (EXT_SB..EXT_LUI, 3 bits), IMM_W = 16 constant, helper function for lane select.
- Sub-module ext_skid_fifo: 2-entry FIFO, params WIDTH (= DATA_W+1), ports clk, reset, push/pop handshake; instantiated once.
- Top: combinational extension + error detect, err_count register, FIFO instance.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1 → out_valid=0, out_data=0, err_count=0, in_ready=0; in_ready=1 after release.
- Modes, DATA_W=32, out_ready=1: in_data=0x80F7_AD6A; SB off 1 → 0xFFFF_FFAD; UB off 3 → 0x0000_0080; SH off 2 → 0xFFFF_80F7; UH off 0 → 0x0000_AD6A; SIMM → 0xFFFF_AD6A; SIMM_SL2 → 0xFFFE_B5A8; LUI → 0xAD6A_0000; W off 0 → 0x80F7_AD6A, each one cycle after acceptance.
- Misalign: SH off 1, W off 2 → out_data=0, out_err=1 each, err_count=2; with ERRCNT_W=2, 5 errors → err_count=3.
- Back-pressure: out_ready=0, 3 back-to-back requests → 2 accepted, in_ready=0 third cycle; raise out_ready → results in original order, in_ready=1 cycle after first pop.
- Streaming: out_ready=1, 10 consecutive requests → 10 results on consecutive cycles, count never exceeds 1.
- Reset mid-operation with count=2 → next cycle out_valid=0, err_count=0; neither buffered entry ever emitted.
